// File: rtl/dcache_port_arb.sv
// dcache_port_arb: single-port D-cache arbiter between the LSU load port
// and the store buffer drain port, one request in flight at a time.
module dcache_port_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [3:0]  ld_rmask,
  output logic        ld_resp,
  output logic [31:0] ld_rdata,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [3:0]  st_wmask,
  input  logic [31:0] st_wdata,
  output logic        st_resp,
  input  logic        st_buf_full,
  output logic [31:0] dc_addr,
  output logic [3:0]  dc_rmask,
  output logic [3:0]  dc_wmask,
  output logic [31:0] dc_wdata,
  input  logic [31:0] dc_rdata,
  input  logic        dc_resp
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    LD_WAIT,
    ST_WAIT
  } state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic          drop;
  logic          idle;
  logic          force_st;

  assign idle     = (state == IDLE) & ~rst;
  assign force_st = st_valid & (st_buf_full | (starve_cnt == LIMIT));

  // a store wins when forced or when no load is granted
  assign ld_ready = idle & ~force_st & ld_valid & ~flush;
  assign st_ready = idle & st_valid & ~ld_ready;

  // a flushed load still completes at the cache but is never reported
  assign ld_resp  = (state == LD_WAIT) & dc_resp & ~drop & ~flush;
  assign st_resp  = (state == ST_WAIT) & dc_resp;
  assign ld_rdata = ld_resp ? dc_rdata : '0;

  // grant, hold the cache request until completion, track load streaks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      drop       <= 1'b0;
      dc_addr    <= '0;
      dc_rmask   <= '0;
      dc_wmask   <= '0;
      dc_wdata   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ld_ready) begin
            state    <= LD_WAIT;
            dc_addr  <= ld_addr;
            dc_rmask <= ld_rmask;
            dc_wmask <= '0;
            dc_wdata <= '0;
            drop     <= flush;
            if (!st_valid)
              starve_cnt <= '0;
            else if (starve_cnt != LIMIT)
              starve_cnt <= starve_cnt + CW'(1);
          end else if (st_ready) begin
            state      <= ST_WAIT;
            dc_addr    <= st_addr;
            dc_rmask   <= '0;
            dc_wmask   <= st_wmask;
            dc_wdata   <= st_wdata;
            starve_cnt <= '0;
          end else if (!st_valid) begin
            starve_cnt <= '0;
          end
        end
        LD_WAIT: begin
          if (dc_resp) begin
            state    <= IDLE;
            dc_rmask <= '0;
            dc_wmask <= '0;
            drop     <= 1'b0;
          end else if (flush) begin
            drop <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (dc_resp) begin
            state    <= IDLE;
            dc_rmask <= '0;
            dc_wmask <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_port_arb.sv
// tb_dcache_port_arb: grant table, scoreboarded load/store transactions,
// starvation, flush and reset corner cases for dcache_port_arb.
module tb_dcache_port_arb;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [3:0]  ld_rmask;
  logic        ld_resp;
  logic [31:0] ld_rdata;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [3:0]  st_wmask;
  logic [31:0] st_wdata;
  logic        st_resp;
  logic        st_buf_full;
  logic [31:0] dc_addr;
  logic [3:0]  dc_rmask;
  logic [3:0]  dc_wmask;
  logic [31:0] dc_wdata;
  logic [31:0] dc_rdata;
  logic        dc_resp;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic ld_v;
    logic st_v;
    logic full;
    logic fl;
    logic exp_lr;
    logic exp_sr;
  } vec_t;

  typedef struct {
    bit          is_ld;
    logic [31:0] data;
  } sb_t;

  vec_t vt[9];
  sb_t  sb[$];

  dcache_port_arb #(.STARVE_LIMIT(4)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_addr(ld_addr),
    .ld_rmask(ld_rmask),
    .ld_resp(ld_resp),
    .ld_rdata(ld_rdata),
    .st_valid(st_valid),
    .st_ready(st_ready),
    .st_addr(st_addr),
    .st_wmask(st_wmask),
    .st_wdata(st_wdata),
    .st_resp(st_resp),
    .st_buf_full(st_buf_full),
    .dc_addr(dc_addr),
    .dc_rmask(dc_rmask),
    .dc_wmask(dc_wmask),
    .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata),
    .dc_resp(dc_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // every response pulse must match the oldest expected transaction
  always @(negedge clk) begin
    if (ld_resp || st_resp) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected ld_resp %b st_resp %b want none",
                 ld_resp, st_resp);
      end else begin
        sb_t e;
        e = sb.pop_front();
        if (ld_resp !== e.is_ld || st_resp !== !e.is_ld ||
            (e.is_ld && ld_rdata !== e.data)) begin
          errors++;
          $display("FAIL sb_resp got ld %b st %b data %h want ld %b data %h",
                   ld_resp, st_resp, ld_rdata, e.is_ld, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [3:0] m,
                         input logic [31:0] d, input int lat);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_rmask = m;
    #1;
    chk("ld_ready", ld_ready, 1);
    sb.push_back('{1'b1, d});
    tick();
    ld_valid = 1'b0;
    ld_rmask = '0;
    for (int i = 1; i < lat; i++) begin
      chk("ld_hold_rmask", dc_rmask, m);
      chk("ld_hold_addr", dc_addr, a);
      tick();
    end
    chk("ld_rmask", dc_rmask, m);
    chk("ld_wmask", dc_wmask, 0);
    dc_resp  = 1'b1;
    dc_rdata = d;
    #1;
    chk("ld_resp", ld_resp, 1);
    chk("ld_rdata", ld_rdata, d);
    tick();
    dc_resp  = 1'b0;
    dc_rdata = '0;
    chk("ld_rmask_clr", dc_rmask, 0);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [3:0] m,
                          input logic [31:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_wmask = m;
    st_wdata = d;
    #1;
    chk("st_ready", st_ready, 1);
    sb.push_back('{1'b0, 32'h0});
    tick();
    st_valid = 1'b0;
    chk("st_addr", dc_addr, a);
    chk("st_wmask", dc_wmask, m);
    chk("st_wdata", dc_wdata, d);
    chk("st_rmask", dc_rmask, 0);
    dc_resp = 1'b1;
    #1;
    chk("st_resp", st_resp, 1);
    tick();
    dc_resp = 1'b0;
    chk("st_wmask_clr", dc_wmask, 0);
  endtask

  task automatic run_starve(input logic [31:0] base);
    bit exp_ld[6];
    exp_ld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    ld_valid = 1'b1;
    st_valid = 1'b1;
    ld_addr  = 32'h3000;
    ld_rmask = 4'hF;
    st_addr  = 32'h4000;
    st_wmask = 4'hF;
    st_wdata = 32'h5555_AAAA;
    for (int g = 0; g < 6; g++) begin
      #1;
      chk("starve_ld_ready", ld_ready, 32'(exp_ld[g]));
      chk("starve_st_ready", st_ready, 32'(!exp_ld[g]));
      sb.push_back('{exp_ld[g], base + 32'(g)});
      tick();
      chk("starve_wait_ready", {ld_ready, st_ready}, 0);
      dc_resp  = 1'b1;
      dc_rdata = base + 32'(g);
      tick();
      dc_resp  = 1'b0;
      dc_rdata = '0;
    end
    ld_valid = 1'b0;
    st_valid = 1'b0;
    ld_rmask = '0;
  endtask

  initial begin
    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    rst         = 1'b1;
    flush       = 1'b0;
    ld_valid    = 1'b0;
    ld_addr     = '0;
    ld_rmask    = '0;
    st_valid    = 1'b0;
    st_addr     = '0;
    st_wmask    = '0;
    st_wdata    = '0;
    st_buf_full = 1'b0;
    dc_rdata    = '0;
    dc_resp     = 1'b0;

    repeat (2) tick();
    chk("rst_dc_addr", dc_addr, 0);
    chk("rst_dc_rmask", dc_rmask, 0);
    chk("rst_dc_wmask", dc_wmask, 0);
    chk("rst_dc_wdata", dc_wdata, 0);
    chk("rst_resp", {ld_resp, st_resp}, 0);
    chk("rst_ready", {ld_ready, st_ready}, 0);
    rst = 1'b0;
    tick();

    // idle grant decisions, valids dropped before every edge
    for (int i = 0; i < 9; i++) begin
      ld_valid    = vt[i].ld_v;
      st_valid    = vt[i].st_v;
      st_buf_full = vt[i].full;
      flush       = vt[i].fl;
      ld_rmask    = 4'hF;
      #1;
      chk($sformatf("grant%0d_ld_ready", i), ld_ready, 32'(vt[i].exp_lr));
      chk($sformatf("grant%0d_st_ready", i), st_ready, 32'(vt[i].exp_sr));
      ld_valid    = 1'b0;
      st_valid    = 1'b0;
      st_buf_full = 1'b0;
      flush       = 1'b0;
      ld_rmask    = '0;
      tick();
    end

    do_load(32'h0000_1004, 4'hF, 32'hDEAD_BEEF, 3);
    do_store(32'h0000_2000, 4'h3, 32'h0000_ABCD);
    do_load(32'h0000_1003, 4'h1, 32'h1234_5678, 1);

    run_starve(32'h100);
    tick();
    run_starve(32'h200);

    // flush one cycle after accept, completion a cycle later
    ld_valid = 1'b1;
    ld_addr  = 32'h6000;
    ld_rmask = 4'hF;
    #1;
    chk("fl_ld_ready", ld_ready, 1);
    tick();
    ld_valid = 1'b0;
    flush    = 1'b1;
    #1;
    chk("fl_no_resp_a", ld_resp, 0);
    tick();
    flush    = 1'b0;
    dc_resp  = 1'b1;
    dc_rdata = 32'hBAD0_BAD0;
    #1;
    chk("fl_no_resp_b", ld_resp, 0);
    tick();
    dc_resp  = 1'b0;
    dc_rdata = '0;
    chk("fl_rmask_clr", dc_rmask, 0);
    do_store(32'h0000_7000, 4'hC, 32'hCAFE_0000);

    // flush landing on the completion cycle
    ld_valid = 1'b1;
    ld_rmask = 4'h3;
    #1;
    chk("flr_ld_ready", ld_ready, 1);
    tick();
    ld_valid = 1'b0;
    flush    = 1'b1;
    dc_resp  = 1'b1;
    dc_rdata = 32'hBAD1_BAD1;
    #1;
    chk("flr_no_resp", ld_resp, 0);
    tick();
    flush   = 1'b0;
    dc_resp = 1'b0;
    do_load(32'h0000_8000, 4'hF, 32'h0BAD_F00D, 2);

    // stray completion while idle
    dc_resp = 1'b1;
    #1;
    chk("stray_resp", {ld_resp, st_resp}, 0);
    tick();
    dc_resp = 1'b0;
    chk("stray_rmask", dc_rmask, 0);
    do_load(32'h0000_9000, 4'hF, 32'h7777_8888, 1);

    // reset in the middle of a store
    st_valid = 1'b1;
    st_addr  = 32'hA000;
    st_wmask = 4'hF;
    st_wdata = 32'h1111_2222;
    #1;
    chk("rs_st_ready", st_ready, 1);
    tick();
    st_valid = 1'b0;
    chk("rs_wmask", dc_wmask, 4'hF);
    #1;
    rst = 1'b1;
    #1;
    chk("rs_dc_addr", dc_addr, 0);
    chk("rs_dc_wmask", dc_wmask, 0);
    chk("rs_dc_wdata", dc_wdata, 0);
    chk("rs_st_resp", st_resp, 0);
    tick();
    rst = 1'b0;
    tick();
    dc_resp = 1'b1;
    #1;
    chk("rs_stray", {ld_resp, st_resp}, 0);
    tick();
    dc_resp = 1'b0;
    do_load(32'h0000_B000, 4'hF, 32'h4242_4242, 1);

    repeat (2) tick();
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
